// File: rtl/mem_access_unit_pkg.sv
// Shared constants and request-decode helpers for the load/store sequencer.
package mem_access_unit_pkg;

    localparam logic [1:0] SIZE_BYTE   = 2'b00;
    localparam logic [1:0] SIZE_HALF   = 2'b01;
    localparam logic [1:0] SIZE_WORD   = 2'b10;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_MISAL   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACCESS   = 2'd1;
    localparam logic [1:0] ST_RESP     = 2'd2;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = off[0];
            SIZE_WORD: is_misaligned = (off != 2'b00);
            default:   is_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: lane_enables = 4'b0001 << off;
            SIZE_HALF: lane_enables = off[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: lane_enables = 4'b1111;
            default:   lane_enables = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SIZE_BYTE: lane_wdata = {4{d[7:0]}};
            SIZE_HALF: lane_wdata = {2{d[15:0]}};
            default:   lane_wdata = d;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request, memory and response signals of the load/store sequencer.
interface mem_access_unit_if;

    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;

    logic        MemEn;
    logic        MemWe;
    logic [3:0]  MemByteEn;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData;
    logic        MemAck;

    logic        RespValid;
    logic [31:0] RespData;
    logic [1:0]  RespErr;

    modport slave (
        input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemRData, MemAck,
        output ReqReady, MemEn, MemWe, MemByteEn, MemAddr, MemWData, RespValid, RespData, RespErr
    );

    modport master (
        output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemRData, MemAck,
        input  ReqReady, MemEn, MemWe, MemByteEn, MemAddr, MemWData, RespValid, RespData, RespErr
    );

endinterface

// File: rtl/mem_access_unit_load_lane_extend.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
module load_lane_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (size)
            SIZE_BYTE: data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            SIZE_WORD: data = shifted;
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: one request at a time, word-aligned memory access with
// byte-lane enables, registered extended load response.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input logic               Clk,
    input logic               Reset,
    mem_access_unit_if.slave  bus
);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       off_q;
    logic [1:0]       size_q;
    logic             signed_q;
    logic             write_q;
    logic             err_q;
    logic [31:0]      ext_data;

    // Extended directly from the acked read word so RespData is a plain register.
    load_lane_extend u_extend (
        .rdata    (bus.MemRData),
        .offset   (off_q),
        .size     (size_q),
        .sign_ext (signed_q),
        .data     (ext_data)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            off_q         <= '0;
            size_q        <= '0;
            signed_q      <= 1'b0;
            write_q       <= 1'b0;
            err_q         <= 1'b0;
            bus.ReqReady  <= 1'b1;
            bus.MemEn     <= 1'b0;
            bus.MemWe     <= 1'b0;
            bus.MemByteEn <= '0;
            bus.MemAddr   <= '0;
            bus.MemWData  <= '0;
            bus.RespValid <= 1'b0;
            bus.RespData  <= '0;
            bus.RespErr   <= ERR_OK;
        end else begin
            bus.RespValid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.ReqValid) begin
                        off_q        <= bus.ReqAddr[1:0];
                        size_q       <= bus.ReqSize;
                        signed_q     <= bus.ReqSigned;
                        write_q      <= bus.ReqWrite;
                        cnt          <= '0;
                        state        <= ST_ACCESS;
                        bus.ReqReady <= 1'b0;
                        // A misaligned request idles one cycle in ACCESS with MemEn low so
                        // its response lands at the same 2-cycle latency as a first-cycle ack.
                        if (is_misaligned(bus.ReqSize, bus.ReqAddr[1:0])) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q         <= 1'b0;
                            bus.MemEn     <= 1'b1;
                            bus.MemWe     <= bus.ReqWrite;
                            bus.MemByteEn <= lane_enables(bus.ReqSize, bus.ReqAddr[1:0]);
                            bus.MemAddr   <= {bus.ReqAddr[31:2], 2'b00};
                            bus.MemWData  <= lane_wdata(bus.ReqSize, bus.ReqWData);
                        end
                    end
                end
                ST_ACCESS: begin
                    if (err_q || bus.MemAck || (cnt == CNT_W'(TIMEOUT - 1))) begin
                        state         <= ST_RESP;
                        bus.RespValid <= 1'b1;
                        bus.MemEn     <= 1'b0;
                        bus.MemWe     <= 1'b0;
                        bus.MemByteEn <= '0;
                        bus.MemAddr   <= '0;
                        bus.MemWData  <= '0;
                        if (err_q) begin
                            bus.RespErr  <= ERR_MISAL;
                            bus.RespData <= '0;
                        end else if (bus.MemAck) begin
                            bus.RespErr  <= ERR_OK;
                            bus.RespData <= write_q ? '0 : ext_data;
                        end else begin
                            bus.RespErr  <= ERR_TIMEOUT;
                            bus.RespData <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state        <= ST_IDLE;
                    bus.ReqReady <= 1'b1;
                    bus.RespData <= '0;
                    bus.RespErr  <= ERR_OK;
                end
                default: begin
                    state        <= ST_IDLE;
                    bus.ReqReady <= 1'b1;
                end
            endcase
        end
    end

endmodule
